result_drain_register: RTL

//  Receiving end of a systolic-array column: captures the column's result words as they

---
 rtl/result_drain_register.sv | 138 +++++++++++++
 1 files changed

// File: rtl/result_drain_register.sv
// Result drain register: collects one systolic-array column of DEPTH result
// words, then drains them in capture order over a valid/ready handshake.
`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif

module result_drain_register #(
  parameter int DEPTH = `ARRAYHEIGHT,
  parameter int WIDTH = `DATASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic [WIDTH-1:0] in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_last,
  output logic             busy,
  output logic             drop_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [CW-1:0]       r_wr_cnt;
  logic [CW-1:0]       r_rd_ptr;
  logic                r_drop_err;
  logic [CW-1:0]       w_wr_cnt_nxt;
  logic [CW-1:0]       w_rd_ptr_nxt;
  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic                w_drop_set;
  logic                w_hs;
  logic                w_rd_last;

  assign w_hs      = (r_state == S_DRAIN) && out_ready;
  assign w_rd_last = (r_rd_ptr == C_LAST);

  // Next-state, pointer updates and capture/drop decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_ptr_nxt = r_rd_ptr;
    w_we         = 1'b0;
    w_waddr      = '0;
    w_drop_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (capture_en) begin
          w_we         = 1'b1;
          w_wr_cnt_nxt = C_ONE;
          w_state_nxt  = (DEPTH == 1) ? S_DRAIN : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (capture_en) begin
          w_we         = 1'b1;
          w_waddr      = r_wr_cnt[AW-1:0];
          w_wr_cnt_nxt = r_wr_cnt + C_ONE;
          if (r_wr_cnt == C_LAST) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_hs && w_rd_last) begin
          // Final handshake frees the buffer, so a same-cycle capture
          // becomes word 0 of the next batch instead of a drop.
          w_rd_ptr_nxt = '0;
          w_wr_cnt_nxt = '0;
          w_state_nxt  = S_IDLE;
          if (capture_en) begin
            w_we         = 1'b1;
            w_wr_cnt_nxt = C_ONE;
            w_state_nxt  = (DEPTH == 1) ? S_DRAIN : S_COLLECT;
          end
        end else begin
          if (w_hs) begin
            w_rd_ptr_nxt = r_rd_ptr + C_ONE;
          end
          if (capture_en) begin
            w_drop_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, storage and sticky drop flag; rst beats flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_rd_ptr   <= '0;
      r_drop_err <= 1'b0;
      r_mem      <= '{default: '0};
    end else if (flush) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_rd_ptr   <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_we) begin
        r_mem[w_waddr] <= in;
      end
      if (w_drop_set) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  assign out_valid = (r_state == S_DRAIN);
  assign out       = out_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign out_last  = out_valid && w_rd_last;
  assign busy      = (r_state != S_IDLE);
  assign drop_err  = r_drop_err;

endmodule
